mag_serial: RTL and testbench
=============================

# mag_serial

Parametrised, bit-serial sign-magnitude ⇄ two's-complement converter with a start/done handshake. It converts a WIDTH-bit word in either direction, one magnitude bit per clock, and flags the unrepresentable corner case of each direction. It sits between the switch/number input logic and the display/decode logic. It replaces the fixed 8-bit combinational bit splitter with a mode-selectable, width-generic sequential unit.

## Interface
- WIDTH, 8, word width in bits; legal range is WIDTH ≥ 2.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  request a conversion; sampled only in IDLE.
- mode  in  1  0: two's complement → sign-magnitude; 1: sign-magnitude → two's complement. Sampled on the start edge.
- din  in  WIDTH  operand; sampled on the start edge only.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; dout/exc valid from this cycle.
- dout  out  WIDTH  result register; holds the last result until the next DONE.
- exc  out  1  exception flag for the last result; mode 0: input was the most-negative value (100…0); mode 1: input was negative zero (100…0).

## Operation
- States and transitions:
  - IDLE → SHIFT on start.
  - SHIFT → DONE when bit counter cnt = WIDTH-2 (after WIDTH-1 shift cycles).
  - DONE → IDLE unconditionally.
- On the start edge:
  - Latch din[WIDTH-2:0] into the shift register, and latch din[WIDTH-1] as `neg` plus `mode`.
  - Clear `seen_one`; set cnt = 0.
- Each SHIFT cycle processes the LSB of the shift register (bit b):
  - Output bit = (neg & seen_one) ? ~b : b.
  - seen_one |= b.
  - The output bit shifts into the result register from the MSB side; cnt increments.
  - This is serial negation (copy through the first 1, invert thereafter) of the low WIDTH-1 bits when neg = 1; pass-through when neg = 0.
- On DONE entry, dout is loaded:
  - Mode 0: dout = {neg, processed bits}; exc = neg & ~seen_one.
  - Mode 1: dout = {neg & seen_one, processed bits}; exc = neg & ~seen_one. Negative zero therefore yields dout = 0.
- The internal result register is separate from dout, so dout is unchanged during SHIFT.
- start is ignored while busy = 1, including the DONE cycle. din and mode changes during a conversion have no effect.
- Positive inputs (neg = 0) in either mode: dout = din, exc = 0.

## Timing
- Reset value of every output: busy 0, done 0, dout 0, exc 0. Internal state resets to IDLE, cnt 0, seen_one 0.
- Edge E0 samples start = 1. busy is high from E0 through E(WIDTH), i.e. WIDTH cycles.
- Edge E(WIDTH-1) enters DONE and loads dout/exc. done is high for exactly the cycle between E(WIDTH-1) and E(WIDTH).
- Edge E(WIDTH) returns to IDLE with busy = 0. The earliest next accepted start is sampled at E(WIDTH+1). Throughput is one conversion per WIDTH+1 cycles.
- Latency from start edge to done assertion: WIDTH-1 cycles.
- rst asserted in any state, including mid-SHIFT:
  - On that edge: IDLE, done = 0, dout = 0, exc = 0; the in-flight conversion is discarded and no done is issued.
  - rst has priority over start on the same edge.
- start held high continuously: a new conversion is accepted on every IDLE edge, one per WIDTH+1 cycles.

## Test plan
- WIDTH=8, mode 0, din=0xFB → done 7 cycles after the start edge; dout=0x85, exc=0; busy high for 8 cycles.
- WIDTH=8, mode 0, din=0x80 → dout=0x80, exc=1. Then mode 0, din=0x2A → dout=0x2A, exc=0, and dout holds 0x80 until the second done.
- WIDTH=8, mode 1, din=0x85 → dout=0xFB, exc=0. Then mode 1, din=0x80 → dout=0x00, exc=1.
- WIDTH=8, start mode 0 din=0xFF, then pulse start with din=0x01 in SHIFT and again in the DONE cycle → both extra pulses ignored; a single done with dout=0x81.
- WIDTH=8, start din=0xFB, assert rst at the third SHIFT cycle → next edge busy=0, dout=0, exc=0; no done pulse in the following 10 cycles.
- WIDTH=2: mode 0 din=2'b11 → dout=2'b11, done 1 cycle after start; din=2'b10 → dout=2'b10, exc=1; mode 1 din=2'b11 → dout=2'b11.

Source files
------------

// File: rtl/mag_serial_if.sv
// Handshake and data bundle for the bit-serial sign-magnitude / two's-complement converter.
interface mag_serial_if #(parameter int WIDTH = 8);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             exc;

  modport master (output start, mode, din, input busy, done, dout, exc);
  modport slave  (input start, mode, din, output busy, done, dout, exc);
endinterface

// File: rtl/mag_serial.sv
// Bit-serial converter between sign-magnitude and two's complement, one magnitude bit per clock.
// Negative operands are negated serially: copy bits through the first 1, invert the rest.
module mag_serial #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  mag_serial_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [WIDTH-2:0] result_q, result_d;
  logic             neg_q, neg_d;
  logic             mode_q, mode_d;
  logic             seenOne_q, seenOne_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             exc_q, exc_d;
  logic             outBit;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    result_d  = result_q;
    neg_d     = neg_q;
    mode_d    = mode_q;
    seenOne_d = seenOne_q;
    dout_d    = dout_q;
    exc_d     = exc_q;
    outBit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SHIFT;
          shift_d   = bus.din[WIDTH-2:0];
          neg_d     = bus.din[WIDTH-1];
          mode_d    = bus.mode;
          seenOne_d = 1'b0;
          cnt_d     = '0;
        end
      end
      SHIFT: begin
        outBit      = (neg_q & seenOne_q) ? ~shift_q[0] : shift_q[0];
        seenOne_d   = seenOne_q | shift_q[0];
        shift_d     = shift_q >> 1;
        result_d    = result_q >> 1;
        result_d[WIDTH-2] = outBit;
        cnt_d       = cnt_q + 1'b1;
        // The last bit is folded in on the same edge that publishes the result.
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          dout_d  = {(mode_q ? (neg_q & seenOne_d) : neg_q), result_d};
          exc_d   = neg_q & ~seenOne_d;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      result_q  <= '0;
      neg_q     <= 1'b0;
      mode_q    <= 1'b0;
      seenOne_q <= 1'b0;
      dout_q    <= '0;
      exc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      result_q  <= result_d;
      neg_q     <= neg_d;
      mode_q    <= mode_d;
      seenOne_q <= seenOne_d;
      dout_q    <= dout_d;
      exc_q     <= exc_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.dout = dout_q;
  assign bus.exc  = exc_q;

endmodule

// File: tb/tb_mag_serial.sv
// Self-checking bench for mag_serial at WIDTH=8 and WIDTH=2 against an arithmetic reference model.
module tb_mag_serial;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mag_serial_if #(.WIDTH(8)) bus8 ();
  mag_serial_if #(.WIDTH(2)) bus2 ();

  mag_serial #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  mag_serial #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // k counts edges since the accepting edge; -1 means idle.
  typedef struct {
    int         k;
    logic [7:0] pendDout;
    logic       pendExc;
    logic [7:0] dout;
    logic       exc;
  } model_t;

  model_t m8;
  model_t m2;
  int     nChecks = 0;
  int     nFails  = 0;
  bit     checkEn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pure arithmetic view of the conversion, independent of any serial mechanics.
  function automatic void convert(input int w, input logic mode, input logic [7:0] din,
                                  output logic [7:0] r, output logic e);
    int full;
    int msb;
    int v;
    int mag;
    full = 1 << w;
    msb  = 1 << (w - 1);
    v    = int'(din);
    e    = 1'b0;
    if ((v & msb) == 0) begin
      r = din;
    end else if (!mode) begin
      if (v == msb) begin
        r = din;
        e = 1'b1;
      end else begin
        r = 8'(msb + (full - v));
      end
    end else begin
      mag = v - msb;
      if (mag == 0) begin
        r = 8'h00;
        e = 1'b1;
      end else begin
        r = 8'(full - mag);
      end
    end
  endfunction

  function automatic model_t step(input model_t m, input int w, input logic r,
                                  input logic s, input logic mode, input logic [7:0] din);
    model_t n;
    n = m;
    if (r) begin
      n.k    = -1;
      n.dout = 8'h00;
      n.exc  = 1'b0;
    end else if (n.k < 0) begin
      if (s) begin
        n.k = 0;
        convert(w, mode, din, n.pendDout, n.pendExc);
      end
    end else begin
      n.k++;
      if (n.k == w - 1) begin
        n.dout = n.pendDout;
        n.exc  = n.pendExc;
      end
      if (n.k == w) n.k = -1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m8 = step(m8, 8, rst, bus8.start, bus8.mode, bus8.din);
    m2 = step(m2, 2, rst, bus2.start, bus2.mode, {6'b0, bus2.din});
  end

  always @(posedge clk) begin
    #1;
    if (checkEn) begin
      checkOutput("busy8", bus8.busy, (m8.k >= 0));
      checkOutput("done8", bus8.done, (m8.k == 7));
      checkOutput("dout8", bus8.dout, m8.dout);
      checkOutput("exc8",  bus8.exc,  m8.exc);
      checkOutput("busy2", bus2.busy, (m2.k >= 0));
      checkOutput("done2", bus2.done, (m2.k == 1));
      checkOutput("dout2", bus2.dout, m2.dout[1:0]);
      checkOutput("exc2",  bus2.exc,  m2.exc);
    end
  end

  // Called at a falling edge: present a one-cycle start, return at the next falling edge.
  task automatic applyStimulus(input int which, input logic mode, input logic [7:0] din);
    if (which == 8) begin
      bus8.start = 1'b1;
      bus8.mode  = mode;
      bus8.din   = din;
    end else begin
      bus2.start = 1'b1;
      bus2.mode  = mode;
      bus2.din   = din[1:0];
    end
    @(negedge clk);
    bus8.start = 1'b0;
    bus2.start = 1'b0;
  endtask

  task automatic waitDone(input int which, output int cyc);
    logic d;
    cyc = 1;
    d   = (which == 8) ? bus8.done : bus2.done;
    while (!d && cyc < 20) begin
      @(negedge clk);
      cyc++;
      d = (which == 8) ? bus8.done : bus2.done;
    end
    if (!d) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic countDone(input int which, input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if ((which == 8) ? bus8.done : bus2.done) pulses++;
    end
  endtask

  initial begin
    logic [7:0] r;
    logic       e;
    int         cyc;
    int         pulses;

    m8 = '{-1, 8'h00, 1'b0, 8'h00, 1'b0};
    m2 = '{-1, 8'h00, 1'b0, 8'h00, 1'b0};
    rst = 1'b1;
    bus8.start = 1'b0; bus8.mode = 1'b0; bus8.din = 8'h00;
    bus2.start = 1'b0; bus2.mode = 1'b0; bus2.din = 2'b00;
    checkEn = 1'b1;

    // Hand-computed anchors for the reference model.
    convert(8, 1'b0, 8'hFB, r, e); checkOutput("model_m0_fb", {23'd0, e, r}, {23'd0, 1'b0, 8'h85});
    convert(8, 1'b0, 8'h80, r, e); checkOutput("model_m0_80", {23'd0, e, r}, {23'd0, 1'b1, 8'h80});
    convert(8, 1'b1, 8'h85, r, e); checkOutput("model_m1_85", {23'd0, e, r}, {23'd0, 1'b0, 8'hFB});
    convert(8, 1'b1, 8'h80, r, e); checkOutput("model_m1_80", {23'd0, e, r}, {23'd0, 1'b1, 8'h00});
    convert(2, 1'b1, 8'h03, r, e); checkOutput("model_w2_m1_3", {23'd0, e, r}, {23'd0, 1'b0, 8'h03});

    repeat (3) @(negedge clk);
    checkOutput("reset_dout8", bus8.dout, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed WIDTH=8 conversions");
    applyStimulus(8, 1'b0, 8'hFB);
    waitDone(8, cyc);
    checkOutput("latency_fb", cyc, 32'd8);
    checkOutput("dout_fb", bus8.dout, 32'h85);
    @(negedge clk);

    applyStimulus(8, 1'b0, 8'h80);
    waitDone(8, cyc);
    checkOutput("dout_80", {bus8.exc, bus8.dout}, {1'b1, 8'h80});
    @(negedge clk);
    applyStimulus(8, 1'b0, 8'h2A);
    waitDone(8, cyc);
    checkOutput("dout_2a", {bus8.exc, bus8.dout}, {1'b0, 8'h2A});
    @(negedge clk);

    applyStimulus(8, 1'b1, 8'h85);
    waitDone(8, cyc);
    checkOutput("dout_m1_85", {bus8.exc, bus8.dout}, {1'b0, 8'hFB});
    @(negedge clk);
    applyStimulus(8, 1'b1, 8'h80);
    waitDone(8, cyc);
    checkOutput("dout_m1_80", {bus8.exc, bus8.dout}, {1'b1, 8'h00});
    @(negedge clk);

    $display("[TB] start pulses while busy");
    applyStimulus(8, 1'b0, 8'hFF);
    @(negedge clk);
    bus8.start = 1'b1; bus8.din = 8'h01;
    @(negedge clk);
    bus8.start = 1'b0;
    waitDone(8, cyc);
    checkOutput("dout_ff", bus8.dout, 32'h81);
    bus8.start = 1'b1; bus8.din = 8'h01;
    @(negedge clk);
    bus8.start = 1'b0;
    countDone(8, 10, pulses);
    checkOutput("extra_done_ignored", pulses, 32'd0);

    $display("[TB] reset mid-shift");
    applyStimulus(8, 1'b0, 8'hFB);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_busy", bus8.busy, 32'd0);
    checkOutput("rst_dout", {bus8.exc, bus8.dout}, 32'd0);
    countDone(8, 10, pulses);
    checkOutput("rst_no_done", pulses, 32'd0);

    $display("[TB] start held high");
    bus8.start = 1'b1;
    bus2.start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus8.mode = 1'($urandom_range(0, 1));
      bus8.din  = 8'($urandom);
      bus2.mode = 1'($urandom_range(0, 1));
      bus2.din  = 2'($urandom);
      @(negedge clk);
    end
    bus8.start = 1'b0;
    bus2.start = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] directed WIDTH=2 conversions");
    applyStimulus(2, 1'b0, 8'h03);
    waitDone(2, cyc);
    checkOutput("w2_latency", cyc, 32'd2);
    checkOutput("w2_dout_11", {bus2.exc, bus2.dout}, {1'b0, 2'b11});
    @(negedge clk);
    applyStimulus(2, 1'b0, 8'h02);
    waitDone(2, cyc);
    checkOutput("w2_dout_10", {bus2.exc, bus2.dout}, {1'b1, 2'b10});
    @(negedge clk);
    applyStimulus(2, 1'b1, 8'h03);
    waitDone(2, cyc);
    checkOutput("w2_m1_dout_11", {bus2.exc, bus2.dout}, {1'b0, 2'b11});
    @(negedge clk);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(0, 63) == 0);
      bus8.start = 1'($urandom_range(0, 1));
      bus8.mode  = 1'($urandom_range(0, 1));
      bus8.din   = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
      bus2.start = 1'($urandom_range(0, 1));
      bus2.mode  = 1'($urandom_range(0, 1));
      bus2.din   = 2'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    bus8.start = 1'b0;
    bus2.start = 1'b0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
